// File: rtl/timer_led_decoder.sv
// Receive-side monitor for the timer LED toggle lines: rebuilds HH:MM:SS,
// measures the second interval and flags rate, sequencing and stall faults.

module timer_led_sync (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic clear,
    input  logic line,
    output logic edge_det
);
    // sync[0..2] = stage 1..3; lines idle high so the chain resets to 1
    logic [2:0] sync;

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n)   sync <= '1;
        else if (clear) sync <= '1;
        else            sync <= {sync[1:0], line};
    end

    assign edge_det = sync[1] ^ sync[2];
endmodule

module timer_led_window #(
    parameter int SYNC_WINDOW = 4
) (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic clear,
    input  logic arm,
    input  logic hit,
    output logic err
);
    localparam int WW = $clog2(SYNC_WINDOW + 1);

    logic          pend;
    logic [WW-1:0] win;

    // arm: wrapping sec edge; hit: the checked line's edge
    always_comb begin
        err = 1'b0;
        if (arm)      err = pend && !hit;
        else if (hit) err = !pend;
        else          err = pend && (win == WW'(1));
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
            win  <= '0;
        end else if (clear) begin
            pend <= 1'b0;
            win  <= '0;
        end else if (arm) begin
            pend <= !hit;
            win  <= WW'(SYNC_WINDOW);
        end else if (hit) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (win == WW'(1)) pend <= 1'b0;
            else               win  <= win - WW'(1);
        end
    end
endmodule

module timer_led_decoder #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int TOL          = 1000,
    parameter int SYNC_WINDOW  = 4,
    parameter int PW           = $clog2(2*CLKS_PER_SEC+1)
) (
    input  logic          clk_50m,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          n_sec_led,
    input  logic          n_min_led,
    input  logic          n_hour_led,
    output logic          sec_tick,
    output logic [5:0]    sec_cnt,
    output logic [5:0]    min_cnt,
    output logic [4:0]    hour_cnt,
    output logic [PW-1:0] sec_period,
    output logic          rate_err,
    output logic          seq_err,
    output logic          stall
);
    localparam logic [PW-1:0] SAT = PW'(2*CLKS_PER_SEC);

    typedef enum logic {IDLE, TRACK} state_t;
    state_t state, state_nxt;

    logic [2:0]    lines, edges;
    logic          sec_edge, min_edge, hour_edge;
    logic          wrap_s, wrap_m, min_err, hour_err;
    logic          measure, stall_hit, rate_bad;
    logic [PW-1:0] interval, meas;

    assign lines = {n_hour_led, n_min_led, n_sec_led};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        timer_led_sync u_sync (
            .clk_50m (clk_50m),
            .reset_n (reset_n),
            .clear   (clear),
            .line    (lines[i]),
            .edge_det(edges[i])
        );
    end

    assign {hour_edge, min_edge, sec_edge} = edges;
    assign wrap_s = sec_edge && (sec_cnt == 6'd59);
    assign wrap_m = wrap_s && (min_cnt == 6'd59);

    timer_led_window #(.SYNC_WINDOW(SYNC_WINDOW)) u_min_win (
        .clk_50m(clk_50m), .reset_n(reset_n), .clear(clear),
        .arm(wrap_s), .hit(min_edge), .err(min_err)
    );

    timer_led_window #(.SYNC_WINDOW(SYNC_WINDOW)) u_hour_win (
        .clk_50m(clk_50m), .reset_n(reset_n), .clear(clear),
        .arm(wrap_m), .hit(hour_edge), .err(hour_err)
    );

    // interval holds clocks since the last edge minus one, hence the +1
    assign meas     = interval + PW'(1);
    assign rate_bad = (int'(meas) > CLKS_PER_SEC + TOL) || (int'(meas) < CLKS_PER_SEC - TOL);

    always_comb begin
        state_nxt = state;
        measure   = 1'b0;
        stall_hit = 1'b0;
        case (state)
            IDLE:  if (sec_edge) state_nxt = TRACK;
            TRACK: begin
                if (sec_edge) begin
                    measure = 1'b1;
                end else if (interval == SAT - PW'(1)) begin
                    stall_hit = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n)   state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            sec_tick   <= 1'b0;
            sec_cnt    <= '0;
            min_cnt    <= '0;
            hour_cnt   <= '0;
            sec_period <= '0;
            rate_err   <= 1'b0;
            seq_err    <= 1'b0;
            stall      <= 1'b0;
            interval   <= '0;
        end else if (clear) begin
            sec_tick   <= 1'b0;
            sec_cnt    <= '0;
            min_cnt    <= '0;
            hour_cnt   <= '0;
            sec_period <= '0;
            rate_err   <= 1'b0;
            seq_err    <= 1'b0;
            stall      <= 1'b0;
            interval   <= '0;
        end else begin
            sec_tick <= sec_edge;
            if (sec_edge)           interval <= '0;
            else if (interval != SAT) interval <= interval + PW'(1);
            if (sec_edge) sec_cnt <= wrap_s ? 6'd0 : sec_cnt + 6'd1;
            if (wrap_s)   min_cnt <= wrap_m ? 6'd0 : min_cnt + 6'd1;
            if (wrap_m)   hour_cnt <= (hour_cnt == 5'd23) ? 5'd0 : hour_cnt + 5'd1;
            if (measure) begin
                sec_period <= meas;
                if (rate_bad) rate_err <= 1'b1;
            end
            if (stall_hit)           stall   <= 1'b1;
            if (min_err || hour_err) seq_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_timer_led_decoder.sv
// Randomised and directed bench for timer_led_decoder against an event-level
// model built on total seconds, tick timestamps and window deadlines.

module tb_timer_led_decoder;
    localparam int CPS = 100;
    localparam int TOL = 2;
    localparam int SW  = 4;
    localparam int PW  = $clog2(2*CPS+1);
    localparam int VW  = 21 + PW;

    logic          clk_50m = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          n_sec_led = 1'b1, n_min_led = 1'b1, n_hour_led = 1'b1;
    logic          sec_tick, rate_err, seq_err, stall;
    logic [5:0]    sec_cnt, min_cnt;
    logic [4:0]    hour_cnt;
    logic [PW-1:0] sec_period;

    timer_led_decoder #(.CLKS_PER_SEC(CPS), .TOL(TOL), .SYNC_WINDOW(SW)) dut (
        .clk_50m(clk_50m), .reset_n(reset_n), .clear(clear),
        .n_sec_led(n_sec_led), .n_min_led(n_min_led), .n_hour_led(n_hour_led),
        .sec_tick(sec_tick), .sec_cnt(sec_cnt), .min_cnt(min_cnt), .hour_cnt(hour_cnt),
        .sec_period(sec_period), .rate_err(rate_err), .seq_err(seq_err), .stall(stall)
    );

    always #10 clk_50m = ~clk_50m;

    int nvec = 0, nerr = 0, ncyc = 0, sched = 0, ticks_seen = 0;
    bit chk_en = 1'b1;

    // model: edges land 2 posedges after the cycle a line is driven
    int qs[$], qm[$], qh[$];
    int tot, last, m_period, pm_due, ph_due;
    bit trk, m_tick, m_rate, m_seq, m_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    task automatic m_reset();
        qs.delete(); qm.delete(); qh.delete();
        tot = 0; last = 0; m_period = 0; pm_due = -1; ph_due = -1;
        trk = 0; m_tick = 0; m_rate = 0; m_seq = 0; m_stall = 0;
    endtask

    task automatic m_win(input bit wrap, input bit hit, input int n, inout int due);
        if (wrap) begin
            if (hit) due = -1;
            else begin
                if (due >= 0) m_seq = 1;
                due = n + SW;
            end
        end else if (hit) begin
            if (due >= 0) due = -1;
            else          m_seq = 1;
        end else if (due >= 0 && n == due) begin
            m_seq = 1;
            due = -1;
        end
    endtask

    task automatic m_step(input int n, input bit ts, input bit tm, input bit th, input bit clr);
        bit se, me, he, ws, wm;
        if (clr) begin
            m_reset();
            return;
        end
        se = 0; me = 0; he = 0; ws = 0; wm = 0;
        if (qs.size() != 0 && qs[0] == n) begin se = 1; void'(qs.pop_front()); end
        if (qm.size() != 0 && qm[0] == n) begin me = 1; void'(qm.pop_front()); end
        if (qh.size() != 0 && qh[0] == n) begin he = 1; void'(qh.pop_front()); end
        if (ts) qs.push_back(n + 2);
        if (tm) qm.push_back(n + 2);
        if (th) qh.push_back(n + 2);
        m_tick = se;
        if (trk && !se && n - last == 2*CPS) begin
            m_stall = 1;
            trk = 0;
        end
        if (se) begin
            if (trk) begin
                m_period = n - last;
                if (m_period > CPS + TOL || m_period < CPS - TOL) m_rate = 1;
            end
            trk  = 1;
            last = n;
            ws   = (tot % 60 == 59);
            wm   = (tot % 3600 == 3599);
            tot  = (tot + 1) % 86400;
        end
        m_win(ws, me, n, pm_due);
        m_win(wm, he, n, ph_due);
    endtask

    function automatic logic [VW-1:0] m_vec();
        return {m_tick, 6'(tot % 60), 6'((tot / 60) % 60), 5'(tot / 3600),
                PW'(m_period), m_rate, m_seq, m_stall};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {sec_tick, sec_cnt, min_cnt, hour_cnt, sec_period, rate_err, seq_err, stall};
    endfunction

    // clear doubles as the generator's reset_timer, returning lines to idle
    task automatic step(input bit ts, input bit tm, input bit th, input bit clr);
        @(negedge clk_50m);
        clear = clr;
        if (clr) begin
            n_sec_led = 1'b1; n_min_led = 1'b1; n_hour_led = 1'b1;
            sched = 0;
        end else begin
            if (ts) n_sec_led  = ~n_sec_led;
            if (tm) n_min_led  = ~n_min_led;
            if (th) n_hour_led = ~n_hour_led;
        end
        @(posedge clk_50m);
        ncyc++;
        m_step(ncyc, ts && !clr, tm && !clr, th && !clr, clr);
        #1;
        if (sec_tick) ticks_seen++;
        if (chk_en) chk("cycle", dut_vec(), m_vec());
    endtask

    // moff < 0 omits the min/hour edges at a wrap
    task automatic secs(input int nticks, input int per, input int moff);
        for (int k = 0; k < nticks; k++) begin
            bit ws, wm;
            ws = (sched % 60 == 59);
            wm = (sched % 3600 == 3599);
            sched = (sched + 1) % 86400;
            for (int c = 0; c < per; c++)
                step(c == 0, ws && c == moff, wm && c == moff, 1'b0);
        end
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk_50m);
        #1 chk("reset", dut_vec(), '0);
        @(negedge clk_50m) reset_n = 1'b1;

        repeat (50) step(0, 0, 0, 0);
        chk("idle_ticks", ticks_seen, 0);

        ticks_seen = 0;
        secs(61, CPS, 2);
        chk("ticks61", ticks_seen, 61);
        chk("hms_1_1", {hour_cnt, min_cnt, sec_cnt}, {5'd0, 6'd1, 6'd1});
        chk("period100", sec_period, 100);
        chk("flags_clean", {rate_err, seq_err, stall}, 3'b000);

        repeat (102) step(0, 0, 0, 0);
        chk("stall_199", stall, 0);
        step(0, 0, 0, 0);
        chk("stall_200", stall, 1);

        secs(1, 102, -1);
        chk("restart_period", sec_period, 100);
        chk("restart_rate", rate_err, 0);
        secs(1, 98, -1);
        chk("p102", {sec_period, rate_err}, {PW'(102), 1'b0});
        secs(1, 103, -1);
        chk("p98", {sec_period, rate_err}, {PW'(98), 1'b0});
        secs(1, 100, -1);
        chk("p103", {sec_period, rate_err}, {PW'(103), 1'b1});
        secs(1, 100, -1);
        chk("rate_sticky", rate_err, 1);

        while (sched % 60 != 30) secs(1, 3, 0);
        chk("sec30", sec_cnt, 30);
        chk("seq_before", seq_err, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("stray_min", seq_err, 1);

        step(0, 0, 0, 1);
        chk("clear_all", dut_vec(), '0);
        secs(60, 2, -1);
        repeat (4) step(0, 0, 0, 0);
        chk("miss_min_early", seq_err, 0);
        step(0, 0, 0, 0);
        chk("miss_min_late", seq_err, 1);
        chk("wrap_counts", {min_cnt, sec_cnt}, {6'd1, 6'd0});

        step(0, 0, 0, 1);
        for (int k = 0; k < 120; k++) begin
            int per, moff;
            bit ws, wm, stray;
            moff = $urandom_range(0, SW + 1);
            per  = ($urandom_range(0, 14) == 0) ? $urandom_range(CPS - 5, CPS + 5)
                                                : $urandom_range(moff + 1, 8);
            ws = (sched % 60 == 59);
            wm = (sched % 3600 == 3599);
            sched = (sched + 1) % 86400;
            for (int c = 0; c < per; c++) begin
                stray = (c != 0) && ($urandom_range(0, 59) == 0);
                step(c == 0, (ws && c == moff) || stray, wm && c == moff, 1'b0);
            end
        end

        step(0, 0, 0, 1);
        chk_en = 1'b0;
        secs(86399, 1, 0);
        chk_en = 1'b1;
        repeat (2) step(0, 0, 0, 0);
        chk("hms_23_59_59", {hour_cnt, min_cnt, sec_cnt}, {5'd23, 6'd59, 6'd59});
        chk("preload_seq", seq_err, 0);
        secs(1, 6, 1);
        chk("hms_rollover", {hour_cnt, min_cnt, sec_cnt}, 17'd0);
        chk("rollover_seq", seq_err, 0);

        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("clr_vs_edge", dut_vec(), '0);
        ticks_seen = 0;
        repeat (5) step(0, 0, 0, 0);
        chk("clr_edge_dropped", ticks_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
